// File: rtl/hack_cpu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hack_cpu_ctrl: multi-cycle Hack fetch/decode/sequencer around external ALU |
// | Optional: HACK_CPU_HALT_EN adds sticky 'halted' on jump-to-self            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hack_cpu_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [15:0]       pc,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       in_m,
  output logic [15:0]       alu_x,
  output logic [15:0]       alu_y,
  output logic              zx,
  output logic              nx,
  output logic              zy,
  output logic              ny,
  output logic              f,
  output logic              no,
  input  logic [15:0]       alu_o,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
`ifdef HACK_CPU_HALT_EN
  output logic              halted,
`endif
  output logic [15:0]       a_reg,
  output logic [15:0]       d_reg
);

  localparam logic [1:0] c_st_fetch = 2'd0;
  localparam logic [1:0] c_st_exec  = 2'd1;
  localparam logic [1:0] c_st_memwr = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [15:0]       r_ir;
  logic [15:0]       r_pc;
  logic [15:0]       r_a;
  logic [15:0]       r_d;
  logic [15:0]       r_wdata;
  logic [ADDR_W-1:0] r_maddr;
  logic [15:0]       w_pc_inc;
  logic              w_accept;
  logic              w_jump;
  logic              w_exec_c;
  logic              w_halted;

  assign w_pc_inc = r_pc + 16'd1;
  assign w_accept = instr_ready & instr_valid;
  assign w_exec_c = (r_state == c_st_exec) & r_ir[15];
  assign w_jump   = (r_ir[2] & alu_ng) | (r_ir[1] & alu_zr) | (r_ir[0] & ~alu_ng & ~alu_zr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_fetch;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_fetch: if (w_accept) w_next_state = c_st_exec;
      c_st_exec:  w_next_state = (r_ir[15] & r_ir[3]) ? c_st_memwr : c_st_fetch;
      c_st_memwr: if (mem_ready) w_next_state = c_st_fetch;
      default:    w_next_state = c_st_fetch;
    endcase
  end

  // rst_n gates instr_ready so no handshake can be seen while reset is held
  always_comb begin
    instr_ready = rst_n & (r_state == c_st_fetch) & ~w_halted;
    mem_we      = (r_state == c_st_memwr);
    {zx, nx, zy, ny, f, no} = w_exec_c ? r_ir[11:6] : 6'b000000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir    <= 16'h0000;
      r_pc    <= RESET_PC;
      r_a     <= 16'h0000;
      r_d     <= 16'h0000;
      r_wdata <= 16'h0000;
      r_maddr <= '0;
    end else begin
      if (w_accept) r_ir <= instr;
      if (r_state == c_st_exec) begin
        if (!r_ir[15]) begin
          r_a  <= {1'b0, r_ir[14:0]};
          r_pc <= w_pc_inc;
        end else begin
          // jump target and write address both use A before this instruction's A write
          r_pc <= w_jump ? r_a : w_pc_inc;
          if (r_ir[5]) r_a <= alu_o;
          if (r_ir[4]) r_d <= alu_o;
          if (r_ir[3]) begin
            r_wdata <= alu_o;
            r_maddr <= r_a[ADDR_W-1:0];
          end
        end
      end
    end
  end

`ifdef HACK_CPU_HALT_EN
  logic r_halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_halted <= 1'b0;
    else if (w_exec_c && (r_ir[2:0] == 3'b111) && (r_a == r_pc))
      r_halted <= 1'b1;
  end

  assign w_halted = r_halted;
  assign halted   = r_halted;
`else
  assign w_halted = 1'b0;
`endif

  assign pc        = r_pc;
  assign alu_x     = r_d;
  assign alu_y     = (r_ir[15] & r_ir[12]) ? in_m : r_a;
  assign mem_addr  = (r_state == c_st_memwr) ? r_maddr : r_a[ADDR_W-1:0];
  assign mem_wdata = r_wdata;
  assign a_reg     = r_a;
  assign d_reg     = r_d;

endmodule
`default_nettype wire

// File: tb/tb_hack_cpu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hack_cpu_ctrl: directed vectors for hack_cpu_ctrl with a Hack ALU model |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_hack_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] pc;
  logic [15:0] instr = 16'h0000;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] in_m;
  logic [15:0] alu_x, alu_y, alu_o;
  logic        zx, nx, zy, ny, f, no;
  logic        alu_zr, alu_ng;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_ready = 1'b1;
  logic [15:0] a_reg, d_reg;
`ifdef HACK_CPU_HALT_EN
  logic        halted;
`endif

  always #5 clk = ~clk;

  hack_cpu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .in_m(in_m), .alu_x(alu_x), .alu_y(alu_y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .alu_o(alu_o), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ready(mem_ready),
`ifdef HACK_CPU_HALT_EN
    .halted(halted),
`endif
    .a_reg(a_reg), .d_reg(d_reg)
  );

  // Reference Hack ALU
  logic [15:0] ax, ay, ao;
  always_comb begin
    ax = zx ? 16'h0000 : alu_x;
    if (nx) ax = ~ax;
    ay = zy ? 16'h0000 : alu_y;
    if (ny) ay = ~ay;
    ao = f ? (ax + ay) : (ax & ay);
    if (no) ao = ~ao;
  end
  assign alu_o  = ao;
  assign alu_zr = (ao == 16'h0000);
  assign alu_ng = ao[15];

  // Small data memory; word 3 preloaded with 9
  logic [15:0] ram [0:255];
  logic        ram_clr = 1'b1;
  assign in_m = ram[mem_addr[7:0]];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= (i == 3) ? 16'd9 : 16'd0;
    end else if (mem_we && mem_ready) begin
      ram[mem_addr[7:0]] <= mem_wdata;
    end
  end

  logic [5:0] ctrl;
  assign ctrl = {zx, nx, zy, ny, f, no};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  logic [5:0]  ex_ctrl;
  logic [15:0] ex_y;

  // Waits for instr_ready, hands over one instruction; returns in the EXEC cycle
  task automatic issue(input logic [15:0] ins);
    int w = 0;
    while (!instr_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (!instr_ready) check("ready_timeout", 32'd0, 32'd1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = 16'hDEAD;
    ex_ctrl = ctrl;
    ex_y = alu_y;
  endtask

  // lat = clock edges after the accepting edge until instr_ready returns
  task automatic run_instr(input logic [15:0] ins, output int lat);
    issue(ins);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!instr_ready && lat < 20);
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] pc;
    logic [5:0]  ctrl;
    int          lat;
  } vec_t;

  vec_t tbl [19];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int we_cnt;

    tbl[0]  = '{16'h0005, 16'd5,   16'd0,    16'd1,  6'h00, 1};  // @5
    tbl[1]  = '{16'hEC10, 16'd5,   16'd5,    16'd2,  6'h30, 1};  // D=A
    tbl[2]  = '{16'h0007, 16'd7,   16'd5,    16'd3,  6'h00, 1};  // @7
    tbl[3]  = '{16'hE301, 16'd7,   16'd5,    16'd7,  6'h0C, 1};  // D;JGT taken
    tbl[4]  = '{16'hE7C8, 16'd7,   16'd5,    16'd8,  6'h1F, 2};  // M=D+1 -> ram[7]=6
    tbl[5]  = '{16'h0000, 16'd0,   16'd5,    16'd9,  6'h00, 1};  // @0
    tbl[6]  = '{16'hEC10, 16'd0,   16'd0,    16'd10, 6'h30, 1};  // D=A
    tbl[7]  = '{16'h0014, 16'd20,  16'd0,    16'd11, 6'h00, 1};  // @20
    tbl[8]  = '{16'hE301, 16'd20,  16'd0,    16'd12, 6'h0C, 1};  // D;JGT not taken
    tbl[9]  = '{16'h0007, 16'd7,   16'd0,    16'd13, 6'h00, 1};  // @7
    tbl[10] = '{16'hFC10, 16'd7,   16'd6,    16'd14, 6'h30, 1};  // D=M
    tbl[11] = '{16'h0003, 16'd3,   16'd6,    16'd15, 6'h00, 1};  // @3
    tbl[12] = '{16'hE4D0, 16'd3,   16'd3,    16'd16, 6'h13, 1};  // D=D-A
    tbl[13] = '{16'hE307, 16'd3,   16'd3,    16'd3,  6'h0C, 1};  // D;JMP
    tbl[14] = '{16'hE090, 16'd3,   16'd6,    16'd4,  6'h02, 1};  // D=D+A
    tbl[15] = '{16'hEE90, 16'd3,   16'hFFFF, 16'd5,  6'h3A, 1};  // D=-1
    tbl[16] = '{16'h0030, 16'd48,  16'hFFFF, 16'd6,  6'h00, 1};  // @48
    tbl[17] = '{16'hE304, 16'd48,  16'hFFFF, 16'd48, 6'h0C, 1};  // D;JLT taken
    tbl[18] = '{16'hE302, 16'd48,  16'hFFFF, 16'd49, 6'h0C, 1};  // D;JEQ not taken

    #1 rst_n = 1'b0;
    #2;
    check("rst_pc", pc, 16'h0000);
    check("rst_a", a_reg, 16'h0000);
    check("rst_d", d_reg, 16'h0000);
    check("rst_ready", instr_ready, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_ctrl", ctrl, 6'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ram_clr = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", instr_ready, 1'b1);

    for (int i = 0; i < 19; i++) begin
      run_instr(tbl[i].ins, lat);
      check($sformatf("v%0d_a", i), a_reg, tbl[i].a);
      check($sformatf("v%0d_d", i), d_reg, tbl[i].d);
      check($sformatf("v%0d_pc", i), pc, tbl[i].pc);
      check($sformatf("v%0d_ctrl", i), ex_ctrl, tbl[i].ctrl);
      check($sformatf("v%0d_lat", i), lat, tbl[i].lat);
    end
    check("ram7", ram[7], 16'd6);

    // M=D+1 at @100 with write back-pressure for three cycles
    run_instr(16'h0064, lat);
    run_instr(16'hEC10, lat);
    check("seq1_d", d_reg, 16'd100);
    mem_ready = 1'b0;
    issue(16'hE7C8);
    @(posedge clk); #1;
    we_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      if (mem_we) we_cnt++;
      if (k == 0) begin
        check("seq1_addr", mem_addr, 15'd100);
        check("seq1_wdata", mem_wdata, 16'd101);
      end
      instr = 16'h0001;
      instr_valid = 1'b1;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    check("seq1_wdata_hold", mem_wdata, 16'd101);
    mem_ready = 1'b1;
    if (mem_we) we_cnt++;
    @(posedge clk); #1;
    check("seq1_we_cycles", we_cnt, 4);
    check("seq1_we_off", mem_we, 1'b0);
    check("seq1_ready", instr_ready, 1'b1);
    check("seq1_ram", ram[100], 16'd101);
    check("seq1_a", a_reg, 16'd100);
    check("seq1_pc", pc, 16'd52);

    // AM=M+1 with A=3, M=9
    run_instr(16'h0003, lat);
    issue(16'hFDE8);
    check("seq2_y", alu_y, 16'd9);
    check("seq2_ctrl", ctrl, 6'b110111);
    @(posedge clk); #1;
    check("seq2_we", mem_we, 1'b1);
    check("seq2_addr", mem_addr, 15'd3);
    check("seq2_wdata", mem_wdata, 16'd10);
    check("seq2_a", a_reg, 16'd10);
    @(posedge clk); #1;
    check("seq2_ready", instr_ready, 1'b1);
    check("seq2_ram", ram[3], 16'd10);
    check("seq2_pc", pc, 16'd54);

    // Reset while a write is pending
    run_instr(16'h0005, lat);
    mem_ready = 1'b0;
    issue(16'hE7C8);
    @(posedge clk); #1;
    check("seq3_we", mem_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("seq3_we_drop", mem_we, 1'b0);
    check("seq3_pc", pc, 16'h0000);
    check("seq3_a", a_reg, 16'h0000);
    check("seq3_ready", instr_ready, 1'b0);
    mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("seq3_ram", ram[5], 16'd0);
    check("seq3_ready_back", instr_ready, 1'b1);

    // Drive pc to 16'hFFFF, then an A-instr wraps it
    run_instr(16'h7FFF, lat);
    run_instr(16'hEC10, lat);
    run_instr(16'hE090, lat);
    check("seq4_d", d_reg, 16'hFFFE);
    run_instr(16'hE320, lat);
    run_instr(16'hEDE0, lat);
    check("seq4_a", a_reg, 16'hFFFF);
    run_instr(16'hEA87, lat);
    check("seq4_pc_ffff", pc, 16'hFFFF);
    run_instr(16'h0001, lat);
    check("seq4_pc_wrap", pc, 16'h0000);
    check("seq4_a1", a_reg, 16'd1);

    // Jump-to-self at pc=2
    run_instr(16'hEA87, lat);
    check("seq5_pc1", pc, 16'd1);
    run_instr(16'h0002, lat);
`ifdef HACK_CPU_HALT_EN
    check("seq5_not_halted", halted, 1'b0);
    issue(16'hEA87);
    instr_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check("seq5_halted", halted, 1'b1);
    check("seq5_ready_low", instr_ready, 1'b0);
    check("seq5_pc", pc, 16'd2);
`else
    run_instr(16'hEA87, lat);
    check("seq5_pc", pc, 16'd2);
    check("seq5_loop_lat", lat, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
